// File: rtl/rf_write_arbiter.sv
// ---------------------------------------------------------------------------
// rf_write_arbiter
//
// Two-requester round-robin arbiter in front of a single register-file write
// port, with a registered write stage and a combinational read bypass.
//
// Requester 0 is the ALU writeback path and requester 1 is the load
// writeback path. A transfer happens on a rising edge when a requester's
// valid and ready are both 1. The granted request appears on the write port
// one cycle later. A write to register 0 is accepted, but it never asserts
// the write enable.
//
// Ports
//   clk           single clock; all state changes on the rising edge
//   reset         asynchronous, active-low reset
//   hold          1 = accept no request this cycle
//   r0_valid/addr/data, r1_valid/addr/data   write requests
//   r0_ready, r1_ready                       grants (at most one is high)
//   mem_we, mem_waddr, mem_wbdata            registered register-file write port
//   rd_addr, mem_rd_data                     read address and raw read data
//   rd_data                                  read data after write bypass
//   conflict_cnt                             saturating count of cycles with
//                                            both requests valid
// ---------------------------------------------------------------------------
module rf_write_arbiter #(
   parameter int DW = 32,
   parameter int AW = 5
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          hold,
   input  logic          r0_valid,
   input  logic [AW-1:0] r0_addr,
   input  logic [DW-1:0] r0_data,
   input  logic          r1_valid,
   input  logic [AW-1:0] r1_addr,
   input  logic [DW-1:0] r1_data,
   output logic          r0_ready,
   output logic          r1_ready,
   output logic          mem_we,
   output logic [AW-1:0] mem_waddr,
   output logic [DW-1:0] mem_wbdata,
   input  logic [AW-1:0] rd_addr,
   input  logic [DW-1:0] mem_rd_data,
   output logic [DW-1:0] rd_data,
   output logic [7:0]    conflict_cnt
);

   // The priority pointer names the requester that wins the next conflict.
   typedef enum logic {
      PRI_R0 = 1'b0,
      PRI_R1 = 1'b1
   } prio_e;

   localparam logic [7:0] CNT_MAX = 8'hFF;

   prio_e          prio_q, prio_d;
   logic           we_q, we_d;
   logic [AW-1:0]  waddr_q, waddr_d;
   logic [DW-1:0]  wbdata_q, wbdata_d;
   logic [7:0]     cnt_q, cnt_d;

   logic           grant0, grant1;
   logic           xfer;
   logic [AW-1:0]  gnt_addr;
   logic [DW-1:0]  gnt_data;
   logic           bypass_hit;

   // ------------------------------------------------------------------------
   // Grant logic. While reset is low, no grant is issued, so a request that
   // is present during reset is not accepted.
   // ------------------------------------------------------------------------
   // NOTE: every signal driven here gets a default first, so no path through
   // the block leaves it unassigned and no latch is inferred.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (reset && !hold) begin
         case ({r1_valid, r0_valid})
            2'b01:   grant0 = 1'b1;
            2'b10:   grant1 = 1'b1;
            2'b11: begin
               if (prio_q == PRI_R0) grant0 = 1'b1;
               else                  grant1 = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // A grant is only given to a valid requester, so a grant is a transfer.
   assign xfer     = grant0 | grant1;
   assign gnt_addr = grant1 ? r1_addr : r0_addr;
   assign gnt_data = grant1 ? r1_data : r0_data;

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      prio_d   = prio_q;
      we_d     = 1'b0;        // the write enable is a single-cycle pulse per transfer
      waddr_d  = waddr_q;
      wbdata_d = wbdata_q;
      cnt_d    = cnt_q;

      if (xfer) begin
         // After a transfer, the requester that did not win gets priority.
         prio_d   = grant0 ? PRI_R1 : PRI_R0;
         // A transfer to register 0 is accepted but never written.
         we_d     = (gnt_addr != '0);
         waddr_d  = gnt_addr;
         wbdata_d = gnt_data;
      end

      // Conflicts are counted whether or not hold is set.
      if (r0_valid && r1_valid && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   // ------------------------------------------------------------------------
   // State registers. Asserting reset discards any pending registered write.
   // ------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments, so every register
   // samples its pre-edge next-state value whatever the statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prio_q   <= PRI_R0;
         we_q     <= 1'b0;
         waddr_q  <= '0;
         wbdata_q <= '0;
         cnt_q    <= '0;
      end else begin
         prio_q   <= prio_d;
         we_q     <= we_d;
         waddr_q  <= waddr_d;
         wbdata_q <= wbdata_d;
         cnt_q    <= cnt_d;
      end
   end

   // ------------------------------------------------------------------------
   // Read bypass: a read of the register being written this cycle returns the
   // data being written. Register 0 is never bypassed.
   // ------------------------------------------------------------------------
   assign bypass_hit = we_q && (waddr_q == rd_addr) && (rd_addr != '0);
   assign rd_data    = bypass_hit ? wbdata_q : mem_rd_data;

   assign r0_ready     = grant0;
   assign r1_ready     = grant1;
   assign mem_we       = we_q;
   assign mem_waddr    = waddr_q;
   assign mem_wbdata   = wbdata_q;
   assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rf_write_arbiter
//
// Self-checking bench for rf_write_arbiter. Inputs change on the falling
// edge. The grants and rd_data are compared before the next rising edge, and
// the registered outputs are compared 1 time unit after that edge.
// Expected values come from a reference model built from the arbitration
// rules:
//   - the granted requester is -1 (none), 0 or 1;
//   - one priority index names the winner of a conflict;
//   - the write port holds plain copies of the last transfer.
// ---------------------------------------------------------------------------
module tb_rf_write_arbiter;

   localparam int DW = 32;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          hold;
   logic          r0_valid, r1_valid;
   logic [AW-1:0] r0_addr, r1_addr, rd_addr;
   logic [DW-1:0] r0_data, r1_data, mem_rd_data;
   logic          r0_ready, r1_ready, mem_we;
   logic [AW-1:0] mem_waddr;
   logic [DW-1:0] mem_wbdata, rd_data;
   logic [7:0]    conflict_cnt;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model state
   int            m_prio;    // 0 or 1: winner of the next conflict
   logic          m_we;
   logic [AW-1:0] m_waddr;
   logic [DW-1:0] m_wbdata;
   int            m_cnt;

   rf_write_arbiter #(.DW(DW), .AW(AW)) dut (
      .clk          (clk),
      .reset        (reset),
      .hold         (hold),
      .r0_valid     (r0_valid),
      .r0_addr      (r0_addr),
      .r0_data      (r0_data),
      .r1_valid     (r1_valid),
      .r1_addr      (r1_addr),
      .r1_data      (r1_data),
      .r0_ready     (r0_ready),
      .r1_ready     (r1_ready),
      .mem_we       (mem_we),
      .mem_waddr    (mem_waddr),
      .mem_wbdata   (mem_wbdata),
      .rd_addr      (rd_addr),
      .mem_rd_data  (mem_rd_data),
      .rd_data      (rd_data),
      .conflict_cnt (conflict_cnt)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic int grant_now();
      if (!reset || hold)         return -1;
      if (r0_valid && r1_valid)   return m_prio;
      if (r0_valid)               return 0;
      if (r1_valid)               return 1;
      return -1;
   endfunction

   function automatic logic [1:0] exp_ready();
      int g = grant_now();
      return {g == 0, g == 1};
   endfunction

   function automatic logic [DW-1:0] exp_rd();
      if (m_we && (m_waddr == rd_addr) && (rd_addr != '0)) return m_wbdata;
      return mem_rd_data;
   endfunction

   task automatic model_reset();
      m_prio = 0; m_we = 1'b0; m_waddr = '0; m_wbdata = '0; m_cnt = 0;
   endtask

   // Advance one rising edge and update the model from the pre-edge inputs.
   task automatic tick();
      int            g    = grant_now();
      bit            both = r0_valid && r1_valid;
      bit            rst  = reset;
      logic [AW-1:0] ga   = (g == 1) ? r1_addr : r0_addr;
      logic [DW-1:0] gd   = (g == 1) ? r1_data : r0_data;
      @(posedge clk);
      if (rst) begin
         if (g >= 0) begin
            m_prio   = 1 - g;
            m_we     = (ga != '0);
            m_waddr  = ga;
            m_wbdata = gd;
         end else begin
            m_we = 1'b0;
         end
         if (both && m_cnt < 255) m_cnt++;
      end
      #1;
   endtask

   task automatic set_inputs(input logic h, input logic v0, input logic v1,
                             input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                             input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                             input logic [AW-1:0] ra, input logic [DW-1:0] rdd);
      @(negedge clk);
      hold = h; r0_valid = v0; r1_valid = v1;
      r0_addr = a0; r1_addr = a1; r0_data = d0; r1_data = d1;
      rd_addr = ra; mem_rd_data = rdd;
      #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      hold = 0; r0_valid = 1; r1_valid = 1; r0_addr = 3; r1_addr = 7;
      r0_data = 32'h1; r1_data = 32'h2; rd_addr = 0; mem_rd_data = 32'h0;
      model_reset();
      #2 reset = 1'b0;
      #1;
      vectors++;
      if ({r0_ready, r1_ready} !== 2'b00) begin
         miscompares++;
         $display("FAIL reset_ready: got %b expected 00", {r0_ready, r1_ready});
      end
      vectors++;
      if ({mem_we, mem_waddr, mem_wbdata, conflict_cnt} !== '0) begin
         miscompares++;
         $display("FAIL reset_regs: got we=%b waddr=%0h wbdata=%0h cnt=%0d expected all 0",
                  mem_we, mem_waddr, mem_wbdata, conflict_cnt);
      end
      tick();   // an edge with requests present while reset is low
      vectors++;
      if ({mem_we, conflict_cnt} !== 9'd0) begin
         miscompares++;
         $display("FAIL reset_edge: got we=%b cnt=%0d expected 0/0", mem_we, conflict_cnt);
      end
      @(negedge clk);
      r0_valid = 0; r1_valid = 0; reset = 1'b1;
   endtask

   task automatic test_priority();
      set_inputs(0, 1, 1, 5'd3, 5'd7, 32'hAAAA, 32'h5555, 5'd0, 32'h0);
      vectors++;
      if ({r0_ready, r1_ready} !== 2'b10) begin
         miscompares++;
         $display("FAIL prio_edge1_ready: got %b expected 10", {r0_ready, r1_ready});
      end
      tick();
      vectors++;
      if ({mem_we, mem_waddr, mem_wbdata} !== {1'b1, 5'd3, 32'hAAAA}) begin
         miscompares++;
         $display("FAIL prio_edge1_write: got we=%b waddr=%0d wbdata=%0h expected 1/3/aaaa",
                  mem_we, mem_waddr, mem_wbdata);
      end
      set_inputs(0, 1, 1, 5'd3, 5'd7, 32'hAAAA, 32'h5555, 5'd0, 32'h0);
      vectors++;
      if ({r0_ready, r1_ready} !== 2'b01) begin
         miscompares++;
         $display("FAIL prio_edge2_ready: got %b expected 01", {r0_ready, r1_ready});
      end
      tick();
      vectors++;
      if ({mem_we, mem_waddr, mem_wbdata, conflict_cnt} !== {1'b1, 5'd7, 32'h5555, 8'd2}) begin
         miscompares++;
         $display("FAIL prio_edge2_write: got we=%b waddr=%0d wbdata=%0h cnt=%0d expected 1/7/5555/2",
                  mem_we, mem_waddr, mem_wbdata, conflict_cnt);
      end
      set_inputs(0, 0, 0, 5'd0, 5'd0, 32'h0, 32'h0, 5'd0, 32'h0);
      tick();
      vectors++;
      if ({mem_we, mem_waddr, mem_wbdata} !== {1'b0, 5'd7, 32'h5555}) begin
         miscompares++;
         $display("FAIL idle_holds: got we=%b waddr=%0d wbdata=%0h expected 0/7/5555",
                  mem_we, mem_waddr, mem_wbdata);
      end
   endtask

   task automatic test_single_and_zero();
      // Only r1 is valid while the pointer names r0.
      set_inputs(0, 0, 1, 5'd0, 5'd9, 32'h0, 32'h1234, 5'd0, 32'h0);
      vectors++;
      if ({r0_ready, r1_ready} !== 2'b01) begin
         miscompares++;
         $display("FAIL single_r1_ready: got %b expected 01", {r0_ready, r1_ready});
      end
      tick();
      vectors++;
      if ({mem_we, mem_waddr, mem_wbdata} !== {1'b1, 5'd9, 32'h1234}) begin
         miscompares++;
         $display("FAIL single_r1_write: got we=%b waddr=%0d wbdata=%0h expected 1/9/1234",
                  mem_we, mem_waddr, mem_wbdata);
      end
      // A write to register 0 is accepted but not written.
      set_inputs(0, 1, 0, 5'd0, 5'd0, 32'hFFFF, 32'h0, 5'd0, 32'h0);
      vectors++;
      if ({r0_ready, r1_ready} !== 2'b10) begin
         miscompares++;
         $display("FAIL zero_addr_ready: got %b expected 10", {r0_ready, r1_ready});
      end
      tick();
      vectors++;
      if (mem_we !== 1'b0) begin
         miscompares++;
         $display("FAIL zero_addr_we: got %b expected 0", mem_we);
      end
   endtask

   task automatic test_hold();
      for (int i = 0; i < 3; i++) begin
         set_inputs(1, 1, 1, 5'd4, 5'd6, 32'h44, 32'h66, 5'd0, 32'h0);
         vectors++;
         if ({r0_ready, r1_ready} !== 2'b00) begin
            miscompares++;
            $display("FAIL hold_ready[%0d]: got %b expected 00", i, {r0_ready, r1_ready});
         end
         tick();
         vectors++;
         if ({mem_we, mem_waddr, mem_wbdata} !== {1'b0, m_waddr, m_wbdata}) begin
            miscompares++;
            $display("FAIL hold_regs[%0d]: got we=%b waddr=%0d wbdata=%0h expected 0/%0d/%0h",
                     i, mem_we, mem_waddr, mem_wbdata, m_waddr, m_wbdata);
         end
      end
      vectors++;
      if (conflict_cnt !== 8'd5) begin
         miscompares++;
         $display("FAIL hold_cnt: got %0d expected 5", conflict_cnt);
      end
      // The pointer was left at r1 by the register-0 write and survives hold.
      set_inputs(0, 1, 1, 5'd4, 5'd6, 32'h44, 32'h66, 5'd0, 32'h0);
      vectors++;
      if ({r0_ready, r1_ready} !== 2'b01) begin
         miscompares++;
         $display("FAIL hold_resume1: got %b expected 01", {r0_ready, r1_ready});
      end
      tick();
      set_inputs(0, 1, 1, 5'd4, 5'd6, 32'h44, 32'h66, 5'd0, 32'h0);
      vectors++;
      if ({r0_ready, r1_ready} !== 2'b10) begin
         miscompares++;
         $display("FAIL hold_resume2: got %b expected 10", {r0_ready, r1_ready});
      end
      tick();
      vectors++;
      if ({mem_we, mem_waddr, conflict_cnt} !== {1'b1, 5'd4, 8'd7}) begin
         miscompares++;
         $display("FAIL hold_resume_write: got we=%b waddr=%0d cnt=%0d expected 1/4/7",
                  mem_we, mem_waddr, conflict_cnt);
      end
   endtask

   task automatic test_bypass();
      set_inputs(0, 1, 0, 5'd5, 5'd0, 32'hBEEF, 32'h0, 5'd0, 32'h0);
      tick();
      set_inputs(0, 0, 0, 5'd0, 5'd0, 32'h0, 32'h0, 5'd5, 32'h0);
      vectors++;
      if (rd_data !== 32'hBEEF) begin
         miscompares++;
         $display("FAIL bypass_hit: got %0h expected beef", rd_data);
      end
      rd_addr = 5'd6; mem_rd_data = 32'h3333; #1;
      vectors++;
      if (rd_data !== 32'h3333) begin
         miscompares++;
         $display("FAIL bypass_other_addr: got %0h expected 3333", rd_data);
      end
      tick();   // the write enable drops, so no bypass even at the same address
      rd_addr = 5'd5; mem_rd_data = 32'h4444; #1;
      vectors++;
      if (rd_data !== 32'h4444) begin
         miscompares++;
         $display("FAIL bypass_we_low: got %0h expected 4444", rd_data);
      end
      set_inputs(0, 1, 0, 5'd0, 5'd0, 32'h7777, 32'h0, 5'd0, 32'h0);
      tick();
      set_inputs(0, 0, 0, 5'd0, 5'd0, 32'h0, 32'h0, 5'd0, 32'h2222);
      vectors++;
      if (rd_data !== 32'h2222) begin
         miscompares++;
         $display("FAIL bypass_reg0: got %0h expected 2222", rd_data);
      end
      tick();
   endtask

   task automatic test_saturation_and_reset();
      for (int i = 0; i < 300; i++) begin
         set_inputs(1'($urandom_range(0, 3) == 0), 1, 1,
                    AW'($urandom_range(1, 31)), AW'($urandom_range(1, 31)),
                    DW'($urandom()), DW'($urandom()), 5'd0, 32'h0);
         vectors++;
         if ({r0_ready, r1_ready} !== exp_ready()) begin
            miscompares++;
            $display("FAIL sat_ready[%0d]: got %b expected %b", i, {r0_ready, r1_ready}, exp_ready());
         end
         tick();
         vectors++;
         if ({mem_we, mem_waddr, mem_wbdata, conflict_cnt} !== {m_we, m_waddr, m_wbdata, 8'(m_cnt)}) begin
            miscompares++;
            $display("FAIL sat_regs[%0d]: got we=%b waddr=%0d wbdata=%0h cnt=%0d expected %b/%0d/%0h/%0d",
                     i, mem_we, mem_waddr, mem_wbdata, conflict_cnt, m_we, m_waddr, m_wbdata, m_cnt);
         end
      end
      vectors++;
      if (conflict_cnt !== 8'd255) begin
         miscompares++;
         $display("FAIL sat_final: got %0d expected 255", conflict_cnt);
      end
      // Assert reset in mid-cycle while a write is pending.
      set_inputs(0, 1, 1, 5'd12, 5'd13, 32'hC0DE, 32'hD00D, 5'd0, 32'h0);
      tick();
      #2 reset = 1'b0;
      #1;
      model_reset();
      vectors++;
      if ({r0_ready, r1_ready, mem_we, mem_waddr, mem_wbdata, conflict_cnt} !== '0) begin
         miscompares++;
         $display("FAIL async_reset: got rdy=%b we=%b waddr=%0d wbdata=%0h cnt=%0d expected all 0",
                  {r0_ready, r1_ready}, mem_we, mem_waddr, mem_wbdata, conflict_cnt);
      end
      set_inputs(0, 0, 0, 5'd0, 5'd0, 32'h0, 32'h0, 5'd0, 32'h0);
      tick();
      @(negedge clk);
      reset = 1'b1;
      tick();
      vectors++;
      if (mem_we !== 1'b0) begin
         miscompares++;
         $display("FAIL post_reset_no_pulse: got %b expected 0", mem_we);
      end
      set_inputs(0, 1, 1, 5'd1, 5'd2, 32'h11, 32'h22, 5'd0, 32'h0);
      vectors++;
      if ({r0_ready, r1_ready} !== 2'b10) begin
         miscompares++;
         $display("FAIL post_reset_prio: got %b expected 10", {r0_ready, r1_ready});
      end
      tick();
   endtask

   task automatic test_random();
      for (int i = 0; i < 500; i++) begin
         set_inputs(1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
                    DW'($urandom()), DW'($urandom()),
                    AW'($urandom_range(0, 7)), DW'($urandom()));
         vectors++;
         if ({r0_ready, r1_ready} !== exp_ready()) begin
            miscompares++;
            $display("FAIL rand_ready[%0d]: got %b expected %b", i, {r0_ready, r1_ready}, exp_ready());
         end
         vectors++;
         if (rd_data !== exp_rd()) begin
            miscompares++;
            $display("FAIL rand_rd_data[%0d]: got %0h expected %0h", i, rd_data, exp_rd());
         end
         tick();
         vectors++;
         if ({mem_we, mem_waddr, mem_wbdata, conflict_cnt} !== {m_we, m_waddr, m_wbdata, 8'(m_cnt)}) begin
            miscompares++;
            $display("FAIL rand_regs[%0d]: got we=%b waddr=%0d wbdata=%0h cnt=%0d expected %b/%0d/%0h/%0d",
                     i, mem_we, mem_waddr, mem_wbdata, conflict_cnt, m_we, m_waddr, m_wbdata, m_cnt);
         end
      end
   endtask

   initial begin
      test_reset();
      test_priority();
      test_single_and_zero();
      test_hold();
      test_bypass();
      test_saturation_and_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
